// File: rtl/apb_requester.sv
// rtl/apb_requester.sv - APB requester: command port to APB SETUP/ACCESS transfers with wait timeout
module apb_requester #(
   parameter int ADDR_W  = 5,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              pclk,
   input  logic              prst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_timeout,
   output logic              pselx,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   input  logic              pready,
   input  logic [DATA_W-1:0] prdata
);

   // TIMEOUT=0 would give a zero-width counter; keep one bit that simply saturates.
   localparam int CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     wait_q, wait_d;
   logic              pselx_q, pselx_d;
   logic              penable_q, penable_d;
   logic              pwrite_q, pwrite_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_timeout_q, rsp_timeout_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

   always_comb begin
      state_d       = state_q;
      wait_d        = wait_q;
      pwrite_d      = pwrite_q;
      paddr_d       = paddr_q;
      pwdata_d      = pwdata_q;
      rsp_valid_d   = 1'b0;
      rsp_timeout_d = 1'b0;
      rsp_rdata_d   = rsp_rdata_q;
      cmd_ready     = 1'b0;

      case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               pwrite_d = cmd_write;
               paddr_d  = cmd_addr;
               pwdata_d = cmd_wdata;
               state_d  = SETUP;
            end
         end
         SETUP: begin
            state_d = ACCESS;
            wait_d  = '0;
         end
         ACCESS: begin
            if (pready) begin
               cmd_ready   = 1'b1;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = pwrite_q ? '0 : prdata;
               // A waiting command chains straight into SETUP without an IDLE bubble.
               if (cmd_valid) begin
                  pwrite_d = cmd_write;
                  paddr_d  = cmd_addr;
                  pwdata_d = cmd_wdata;
                  state_d  = SETUP;
               end else begin
                  state_d = IDLE;
               end
            end else if ((TIMEOUT > 0) && (wait_q == CW'(TO_LAST))) begin
               state_d       = IDLE;
               rsp_valid_d   = 1'b1;
               rsp_timeout_d = 1'b1;
               rsp_rdata_d   = '0;
            end else if (wait_q != {CW{1'b1}}) begin
               wait_d = wait_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      pselx_d   = (state_d != IDLE);
      penable_d = (state_d == ACCESS);
   end

   always_ff @(posedge pclk) begin
      if (!prst_n) begin
         state_q       <= IDLE;
         wait_q        <= '0;
         pselx_q       <= 1'b0;
         penable_q     <= 1'b0;
         pwrite_q      <= 1'b0;
         paddr_q       <= '0;
         pwdata_q      <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_timeout_q <= 1'b0;
         rsp_rdata_q   <= '0;
      end else begin
         state_q       <= state_d;
         wait_q        <= wait_d;
         pselx_q       <= pselx_d;
         penable_q     <= penable_d;
         pwrite_q      <= pwrite_d;
         paddr_q       <= paddr_d;
         pwdata_q      <= pwdata_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_timeout_q <= rsp_timeout_d;
         rsp_rdata_q   <= rsp_rdata_d;
      end
   end

   assign pselx       = pselx_q;
   assign penable     = penable_q;
   assign pwrite      = pwrite_q;
   assign paddr       = paddr_q;
   assign pwdata      = pwdata_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_timeout = rsp_timeout_q;
   assign rsp_rdata   = rsp_rdata_q;

endmodule

// File: tb/tb_apb_requester.sv
// tb/tb_apb_requester.sv - self-checking bench for apb_requester against a transaction-level model
module tb_apb_requester;

   localparam int TO = 16;

   logic        pclk = 1'b0;
   logic        prst_n;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [4:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic        pselx, penable, pwrite;
   logic [4:0]  paddr;
   logic [31:0] pwdata;
   logic        pready;
   logic [31:0] prdata;

   int vecs = 0;
   int errs = 0;

   apb_requester #(.ADDR_W(5), .DATA_W(32), .TIMEOUT(TO)) dut (
      .pclk(pclk), .prst_n(prst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
      .pselx(pselx), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
      .pready(pready), .prdata(prdata)
   );

   always #5 pclk = ~pclk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got running want finished");
      $fatal(1);
   end

   // Transaction model: SETUP is 1 cycle; ACCESS lasts nwait+1 cycles, capped at TO (then timeout).
   task automatic run_txn(input logic wr, input logic [4:0] a, input logic [31:0] wd,
                          input int nwait, input logic [31:0] rd, input logic setup_pready);
      logic        to;
      int          n_acc;
      logic [31:0] exp_rd;
      to     = (nwait >= TO);
      n_acc  = to ? TO : nwait + 1;
      exp_rd = (to || wr) ? 32'h0 : rd;

      @(posedge pclk); #1;
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd;
      pready = 1'($urandom); prdata = $urandom;
      @(negedge pclk);
      vecs++;
      if ({cmd_ready, pselx} !== 2'b10) begin
         errs++; $display("FAIL txn_idle: {cmd_ready,pselx} got %b want 10", {cmd_ready, pselx});
      end

      @(posedge pclk); #1;
      cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = 5'($urandom); cmd_wdata = $urandom;
      pready = setup_pready; prdata = $urandom;
      @(negedge pclk);
      vecs++;
      if ({pselx, penable, rsp_valid, cmd_ready} !== 4'b1000) begin
         errs++; $display("FAIL txn_setup: {psel,pen,rspv,rdy} got %b want 1000", {pselx, penable, rsp_valid, cmd_ready});
      end
      vecs++;
      if ({pwrite, paddr, pwdata} !== {wr, a, wd}) begin
         errs++; $display("FAIL txn_setup_bus: got %h want %h", {pwrite, paddr, pwdata}, {wr, a, wd});
      end

      for (int i = 0; i < n_acc; i++) begin
         @(posedge pclk); #1;
         pready = (i == nwait); prdata = (i == nwait) ? rd : $urandom;
         @(negedge pclk);
         vecs++;
         if ({pselx, penable, rsp_valid, cmd_ready} !== {3'b110, (i == nwait)}) begin
            errs++; $display("FAIL txn_access[%0d]: {psel,pen,rspv,rdy} got %b want %b", i,
                             {pselx, penable, rsp_valid, cmd_ready}, {3'b110, (i == nwait)});
         end
         vecs++;
         if ({pwrite, paddr, pwdata} !== {wr, a, wd}) begin
            errs++; $display("FAIL txn_access_bus[%0d]: got %h want %h", i, {pwrite, paddr, pwdata}, {wr, a, wd});
         end
      end

      @(posedge pclk); #1;
      pready = 1'($urandom); prdata = $urandom;
      @(negedge pclk);
      vecs++;
      if ({pselx, penable, rsp_valid, rsp_timeout} !== {3'b001, to}) begin
         errs++; $display("FAIL txn_rsp: {psel,pen,rspv,rspto} got %b want %b", {pselx, penable, rsp_valid, rsp_timeout}, {3'b001, to});
      end
      vecs++;
      if (rsp_rdata !== exp_rd) begin
         errs++; $display("FAIL txn_rdata: got %h want %h", rsp_rdata, exp_rd);
      end

      @(posedge pclk); #1;
      @(negedge pclk);
      vecs++;
      if ({pselx, rsp_valid, rsp_timeout} !== 3'b000 || rsp_rdata !== exp_rd) begin
         errs++; $display("FAIL txn_hold: {psel,rspv,rspto} got %b rdata %h want 000 rdata %h",
                          {pselx, rsp_valid, rsp_timeout}, rsp_rdata, exp_rd);
      end
      vecs++;
      if ({pwrite, paddr, pwdata} !== {wr, a, wd}) begin
         errs++; $display("FAIL txn_idle_bus_hold: got %h want %h", {pwrite, paddr, pwdata}, {wr, a, wd});
      end
   endtask

   task automatic test_reset;
      prst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      pready = 1'b0; prdata = '0;
      repeat (2) @(posedge pclk);
      #1; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'h1f; cmd_wdata = 32'hffff_ffff;
      @(negedge pclk);
      vecs++;
      if ({pselx, penable, pwrite, rsp_valid, rsp_timeout, paddr, pwdata, rsp_rdata} !== '0) begin
         errs++; $display("FAIL reset_outputs: got %b want all 0",
                          {pselx, penable, pwrite, rsp_valid, rsp_timeout, paddr, pwdata, rsp_rdata});
      end
      vecs++;
      if (cmd_ready !== 1'b1) begin
         errs++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready);
      end
      @(posedge pclk); #1;
      @(negedge pclk);
      vecs++;
      if ({pselx, pwrite, paddr} !== '0) begin
         errs++; $display("FAIL reset_no_capture: got %b want 0", {pselx, pwrite, paddr});
      end
      #1; prst_n = 1'b1; cmd_valid = 1'b0;
   endtask

   task automatic test_write;
      run_txn(1'b1, 5'h03, 32'hDEADBEEF, 0, $urandom, 1'b0);
   endtask

   task automatic test_read_wait;
      run_txn(1'b0, 5'h03, $urandom, 3, 32'hDEADBEEF, 1'b0);
   endtask

   task automatic test_setup_ignores_pready;
      run_txn(1'b0, 5'h0a, $urandom, 0, 32'h1234_5678, 1'b1);
   endtask

   task automatic test_timeout;
      run_txn(1'b0, 5'h11, 32'h0bad_f00d, TO + 4, 32'hcafe_babe, 1'b0);
      run_txn(1'b0, 5'h12, 32'h0, TO - 1, 32'h5555_aaaa, 1'b0);
   endtask

   task automatic test_back_to_back;
      logic [31:0] r2;
      r2 = $urandom;
      @(posedge pclk); #1;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'h05; cmd_wdata = 32'h0102_0304; pready = 1'b0;
      @(negedge pclk);
      vecs++;
      if (cmd_ready !== 1'b1) begin
         errs++; $display("FAIL b2b_idle_ready: got %b want 1", cmd_ready);
      end
      @(posedge pclk); #1;
      cmd_write = 1'b0; cmd_addr = 5'h16; cmd_wdata = 32'h0; pready = 1'b1;
      @(negedge pclk);
      vecs++;
      if ({pselx, penable, cmd_ready, paddr} !== {3'b100, 5'h05}) begin
         errs++; $display("FAIL b2b_setup1: got %b want %b", {pselx, penable, cmd_ready, paddr}, {3'b100, 5'h05});
      end
      @(posedge pclk); #1;
      pready = 1'b1; prdata = $urandom;
      @(negedge pclk);
      vecs++;
      if ({pselx, penable, cmd_ready, paddr} !== {3'b111, 5'h05}) begin
         errs++; $display("FAIL b2b_access1: got %b want %b", {pselx, penable, cmd_ready, paddr}, {3'b111, 5'h05});
      end
      @(posedge pclk); #1;
      cmd_valid = 1'b0; pready = 1'b0;
      @(negedge pclk);
      vecs++;
      if ({pselx, penable, rsp_valid, pwrite, paddr, rsp_rdata} !== {4'b1010, 5'h16, 32'h0}) begin
         errs++; $display("FAIL b2b_setup2: got %h want %h", {pselx, penable, rsp_valid, pwrite, paddr, rsp_rdata},
                          {4'b1010, 5'h16, 32'h0});
      end
      @(posedge pclk); #1;
      pready = 1'b1; prdata = r2;
      @(negedge pclk);
      vecs++;
      if ({pselx, penable, rsp_valid} !== 3'b110) begin
         errs++; $display("FAIL b2b_access2: got %b want 110", {pselx, penable, rsp_valid});
      end
      @(posedge pclk); #1;
      pready = 1'b0;
      @(negedge pclk);
      vecs++;
      if ({pselx, penable, rsp_valid, rsp_timeout, rsp_rdata} !== {4'b0010, r2}) begin
         errs++; $display("FAIL b2b_rsp2: got %h want %h", {pselx, penable, rsp_valid, rsp_timeout, rsp_rdata}, {4'b0010, r2});
      end
   endtask

   task automatic test_reset_mid_transfer;
      @(posedge pclk); #1;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'h09; pready = 1'b0;
      @(posedge pclk); #1;
      cmd_valid = 1'b0;
      repeat (2) begin
         @(posedge pclk); #1;
         pready = 1'b0;
      end
      @(negedge pclk);
      vecs++;
      if ({pselx, penable} !== 2'b11) begin
         errs++; $display("FAIL rst_mid_access: got %b want 11", {pselx, penable});
      end
      #1; prst_n = 1'b0; cmd_valid = 1'b1;
      @(posedge pclk); #1;
      @(negedge pclk);
      vecs++;
      if ({pselx, penable, rsp_valid, cmd_ready, rsp_rdata, paddr} !== {4'b0001, 32'h0, 5'h0}) begin
         errs++; $display("FAIL rst_mid_abort: got %h want %h", {pselx, penable, rsp_valid, cmd_ready, rsp_rdata, paddr},
                          {4'b0001, 32'h0, 5'h0});
      end
      @(posedge pclk); #1;
      prst_n = 1'b1; cmd_valid = 1'b0;
      @(negedge pclk);
      vecs++;
      if ({pselx, rsp_valid} !== 2'b00) begin
         errs++; $display("FAIL rst_mid_after: got %b want 00", {pselx, rsp_valid});
      end
      run_txn(1'b0, 5'h0c, 32'h0, 1, 32'h600d_d00d, 1'b0);
   endtask

   task automatic test_random;
      int nw;
      for (int k = 0; k < 30; k++) begin
         nw = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TO - 1, TO + 3)) : int'($urandom_range(0, 6));
         run_txn(1'($urandom), 5'($urandom), $urandom, nw, $urandom, 1'($urandom));
      end
   endtask

   initial begin
      test_reset;
      test_write;
      test_read_wait;
      test_setup_ignores_pready;
      test_timeout;
      test_back_to_back;
      test_reset_mid_transfer;
      test_random;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
